// File: rtl/vedic_product_accumulator.sv
// Frame accumulator behind the 16x16 Vedic multiplier: sums unsigned products per frame
// and returns the frame sum, term count and a sticky per-frame overflow flag.
module vedic_product_accumulator #(
   parameter int PW     = 32,
   parameter int AW     = 40,
   parameter int MAXLEN = 256
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [PW-1:0]           i_prod_in,
   input  logic                    i_prod_valid,
   input  logic                    i_prod_last,
   output logic                    o_prod_ready,
   output logic [AW-1:0]           o_acc_out,
   output logic [$clog2(MAXLEN):0] o_acc_count,
   output logic                    o_acc_ovf,
   output logic                    o_acc_valid,
   input  logic                    i_acc_ready
);

   localparam int CW = $clog2(MAXLEN) + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]    r_state;
   logic [AW-1:0] r_acc;
   logic [CW-1:0] r_count;
   logic          r_ovf;

   logic          w_beat;
   logic [AW:0]   w_sum;
   logic [CW-1:0] w_count_nx;
   logic          w_first_close;
   logic          w_accum_close;

   // Ready/valid depend only on registered state and reset, never on i_acc_ready.
   assign o_prod_ready = ~i_rst & (r_state != S_DONE);
   assign o_acc_valid  = ~i_rst & (r_state == S_DONE);
   assign o_acc_out    = r_acc;
   assign o_acc_count  = r_count;
   assign o_acc_ovf    = r_ovf;

   assign w_beat        = i_prod_valid & o_prod_ready;
   assign w_sum         = (AW+1)'(r_acc) + (AW+1)'(i_prod_in);
   assign w_count_nx    = r_count + CW'(1);
   assign w_first_close = i_prod_last | (MAXLEN == 1);
   assign w_accum_close = i_prod_last | (int'(w_count_nx) == MAXLEN);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_acc   <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_beat) begin
                  r_acc   <= AW'(i_prod_in);
                  r_count <= CW'(1);
                  r_ovf   <= 1'b0;
                  r_state <= w_first_close ? S_DONE : S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (w_beat) begin
                  // Carry-out of the AW-bit add marks a wrap; sticky until the frame is taken.
                  r_acc   <= w_sum[AW-1:0];
                  r_ovf   <= r_ovf | w_sum[AW];
                  r_count <= w_count_nx;
                  if (w_accum_close) r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (i_acc_ready) begin
                  r_state <= S_IDLE;
                  r_acc   <= '0;
                  r_count <= '0;
                  r_ovf   <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vedic_product_accumulator.sv
// Scoreboard bench: two accumulator configurations share one stimulus stream; a frame-sum
// model pushes expected results, a negedge monitor pops and compares on each taken result.
module tb_vedic_product_accumulator;

   typedef struct {
      logic [63:0] acc;
      logic [63:0] cnt;
      logic [63:0] ovf;
   } res_t;

   logic        clk, rst;
   logic [31:0] prod;
   logic        prod_valid, prod_last, acc_ready;

   logic        a_ready, a_ovf, a_valid;
   logic [39:0] a_acc;
   logic [8:0]  a_cnt;
   logic        b_ready, b_ovf, b_valid;
   logic [31:0] b_acc;
   logic [2:0]  b_cnt;

   int vectors = 0;
   int errors  = 0;

   vedic_product_accumulator #(.PW(32), .AW(40), .MAXLEN(256)) u_a (
      .i_clk(clk), .i_rst(rst), .i_prod_in(prod), .i_prod_valid(prod_valid),
      .i_prod_last(prod_last), .o_prod_ready(a_ready), .o_acc_out(a_acc),
      .o_acc_count(a_cnt), .o_acc_ovf(a_ovf), .o_acc_valid(a_valid), .i_acc_ready(acc_ready));

   vedic_product_accumulator #(.PW(32), .AW(32), .MAXLEN(4)) u_b (
      .i_clk(clk), .i_rst(rst), .i_prod_in(prod), .i_prod_valid(prod_valid),
      .i_prod_last(prod_last), .o_prod_ready(b_ready), .o_acc_out(b_acc),
      .o_acc_count(b_cnt), .o_acc_ovf(b_ovf), .o_acc_valid(b_valid), .i_acc_ready(acc_ready));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
      end
   endtask

   // ---------------- reference model: frame sums with plain wide arithmetic
   res_t q0[$];
   res_t q1[$];
   longint unsigned fsum[2];
   int              fcnt[2];
   int              maxlen[2] = '{256, 4};
   int              aw[2]     = '{40, 32};
   bit              expv[2], expidle[2], hold[2];
   res_t            snap[2];

   task automatic q_push(input int k, input res_t r);
      if (k == 0) q0.push_back(r); else q1.push_back(r);
   endtask

   task automatic q_pop(input int k, output res_t r, output bit ok);
      ok = 1'b0;
      r  = '{default: '0};
      if (k == 0 && q0.size() > 0) begin r = q0.pop_front(); ok = 1'b1; end
      if (k == 1 && q1.size() > 0) begin r = q1.pop_front(); ok = 1'b1; end
   endtask

   function automatic res_t observed(input int k);
      res_t r;
      if (k == 0) begin r.acc = 64'(a_acc); r.cnt = 64'(a_cnt); r.ovf = 64'(a_ovf); end
      else        begin r.acc = 64'(b_acc); r.cnt = 64'(b_cnt); r.ovf = 64'(b_ovf); end
      return r;
   endfunction

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         logic rdy, vld;
         res_t o, e;
         bit ok;
         longint unsigned mask;
         string tag;
         tag  = (k == 0) ? "A" : "B";
         rdy  = (k == 0) ? a_ready : b_ready;
         vld  = (k == 0) ? a_valid : b_valid;
         o    = observed(k);
         mask = (64'd1 << aw[k]) - 64'd1;
         if (rst) begin
            fsum[k] = 0; fcnt[k] = 0;
            expv[k] = 0; expidle[k] = 0; hold[k] = 0;
            if (k == 0) q0.delete(); else q1.delete();
         end else begin
            chk({tag, "_ready_vs_valid"}, 64'(rdy), 64'(!vld));
            if (expv[k]) begin
               chk({tag, "_latency"}, 64'(vld), 64'd1);
               expv[k] = 0;
            end
            if (expidle[k]) begin
               chk({tag, "_idle_clear"}, {vld, o.ovf[0], o.cnt[30:0], o.acc[31:0]}, 64'd0);
               expidle[k] = 0;
            end
            if (vld && hold[k])
               chk({tag, "_hold_stable"}, {o.acc[39:0], o.cnt[8:0], o.ovf[0]},
                   {snap[k].acc[39:0], snap[k].cnt[8:0], snap[k].ovf[0]});
            if (vld) begin
               if (acc_ready) begin
                  q_pop(k, e, ok);
                  chk({tag, "_result_expected"}, 64'(ok), 64'd1);
                  if (ok) begin
                     chk({tag, "_acc"}, o.acc, e.acc);
                     chk({tag, "_count"}, o.cnt, e.cnt);
                     chk({tag, "_ovf"}, o.ovf, e.ovf);
                  end
                  hold[k] = 0; expidle[k] = 1;
               end else begin
                  hold[k] = 1; snap[k] = o;
               end
            end
            if (prod_valid && rdy) begin
               fsum[k] += 64'(prod);
               fcnt[k]++;
               if (prod_last || fcnt[k] == maxlen[k]) begin
                  e.acc = fsum[k] & mask;
                  e.cnt = 64'(fcnt[k]);
                  e.ovf = (fsum[k] > mask) ? 64'd1 : 64'd0;
                  q_push(k, e);
                  fsum[k] = 0; fcnt[k] = 0; expv[k] = 1;
               end
            end
         end
      end
   end

   // ---------------- stimulus
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [31:0] p, input logic l);
      prod = p; prod_last = l; prod_valid = 1'b1;
      tick();
      prod_valid = 1'b0; prod_last = 1'b0;
   endtask

   task automatic release_result();
      acc_ready = 1'b1;
      tick();
      acc_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; prod = '0; prod_valid = 1'b0; prod_last = 1'b0; acc_ready = 1'b0;
      repeat (3) tick();
      chk("reset_state_A", {a_acc, a_cnt, a_ovf, a_valid, a_ready}, 64'd0);
      chk("reset_state_B", {b_acc, b_cnt, b_ovf, b_valid, b_ready}, 64'd0);
      rst = 1'b0; #1;
      chk("ready_after_reset", {a_ready, b_ready}, 64'b11);

      // 1: three-term frame, result held until taken
      send(32'd1, 1'b0); send(32'd2, 1'b0); send(32'd3, 1'b1);
      chk("t1_valid", 64'(a_valid), 64'd1);
      chk("t1_acc", 64'(a_acc), 64'd6);
      chk("t1_count", 64'(a_cnt), 64'd3);
      chk("t1_ovf", 64'(a_ovf), 64'd0);
      repeat (2) tick();
      chk("t1_ready_low", 64'(a_ready), 64'd0);
      release_result();

      // 2: 256 max products, forced close (B closes at 4 with a wrap)
      for (int i = 0; i < 256; i++) send(32'hFFFE_0001, 1'b0);
      chk("t2_valid", 64'(a_valid), 64'd1);
      chk("t2_acc", 64'(a_acc), 64'hFF_FE00_0100);
      chk("t2_count", 64'(a_cnt), 64'd256);
      chk("t2_ovf", 64'(a_ovf), 64'd0);
      chk("t2_B_acc", 64'(b_acc), 64'hFFF8_0004);
      chk("t2_B_count", 64'(b_cnt), 64'd4);
      chk("t2_B_ovf", 64'(b_ovf), 64'd1);
      release_result();
      send(32'd5, 1'b1);
      chk("t2_newframe_acc", 64'(a_acc), 64'd5);
      chk("t2_newframe_count", 64'(a_cnt), 64'd1);
      release_result();

      // 3: wrap in the 32-bit accumulator, exact wrap to zero, then a clean frame
      send(32'hFFFF_FFFF, 1'b0); send(32'd2, 1'b1);
      chk("t3_B_acc", 64'(b_acc), 64'd1);
      chk("t3_B_ovf", 64'(b_ovf), 64'd1);
      chk("t3_A_acc", 64'(a_acc), 64'h1_0000_0001);
      chk("t3_A_ovf", 64'(a_ovf), 64'd0);
      release_result();
      send(32'h8000_0000, 1'b0); send(32'h8000_0000, 1'b1);
      chk("t3_exact_wrap", {b_acc, b_ovf}, 64'h1);
      release_result();
      send(32'd9, 1'b1);
      chk("t3_next_ovf", {b_acc, b_ovf}, 64'h12);
      release_result();

      // 4: result stalled for five cycles
      send(32'h1234_5678, 1'b1);
      for (int i = 0; i < 5; i++) begin
         chk("t4_stall", {a_valid, a_ready, a_cnt, a_acc[31:0]}, {1'b1, 1'b0, 9'd1, 32'h1234_5678});
         tick();
      end
      release_result();
      chk("t4_idle", {a_valid, a_ready, a_cnt, a_ovf, a_acc[31:0]}, {1'b0, 1'b1, 9'd0, 1'b0, 32'd0});

      // 5: reset mid-frame discards the partial sum
      send(32'd1, 1'b0); send(32'd2, 1'b0);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t5_no_result", 64'(a_valid), 64'd0);
      send(32'd7, 1'b1);
      chk("t5_acc", {a_valid, a_cnt, a_acc[31:0]}, {1'b1, 9'd1, 32'd7});
      release_result();

      // 6: random gaps and stalls
      for (int i = 0; i < 4000; i++) begin
         prod_valid = ($urandom_range(9) < 6);
         prod_last  = ($urandom_range(4) == 0);
         case ($urandom_range(3))
            0: prod = 32'($urandom_range(255));
            1: prod = 32'hFFFF_FFFF;
            default: prod = $urandom;
         endcase
         acc_ready = $urandom_range(1) == 1;
         tick();
      end
      prod_valid = 1'b0; prod_last = 1'b0; acc_ready = 1'b1;
      begin
         int n;
         n = 0;
         while ((q0.size() != 0 || q1.size() != 0 || a_valid || b_valid) && n < 50) begin
            tick(); n++;
         end
         chk("drain_in_time", 64'(n < 50), 64'd1);
      end
      tick();
      chk("A_queue_empty", 64'(q0.size()), 64'd0);
      chk("B_queue_empty", 64'(q1.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
